// File: rtl/cdc_hs_pkg.sv
// Shared definitions for the bundled-data request/acknowledge crossing
// (transmitter now, matching receiver later).
package cdc_hs_pkg;

    localparam int HS_MODE_4PH = 0;
    localparam int HS_MODE_2PH = 1;

    typedef enum logic [1:0] {
        HS_IDLE     = 2'd0,
        HS_SETUP    = 2'd1,
        HS_WAIT_ACK = 2'd2,
        HS_WAIT_REL = 2'd3
    } hs_tx_state_e;

endpackage

// File: rtl/cdc_hs_fifo.sv
// Synchronous word FIFO feeding the handshake transmitter; occupancy is a
// registered count so full/level are glitch-free.
module cdc_hs_fifo
    import cdc_hs_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic          clk_tx,
    input  logic          rst_b,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign head    = mem[rd_ptr];

    // Storage is not reset; it is only read behind a non-zero count.
    always_ff @(posedge clk_tx) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk_tx or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/cdc_hs_tx.sv
// Transmit side of a bundled-data req/ack crossing: FIFO, ack synchroniser
// and a 4-phase or 2-phase handshake FSM.
//
//   state       | meaning
//   HS_IDLE     | no open handshake; pops the FIFO head into dout if present
//   HS_SETUP    | dout settling for one cycle; req moves on exit
//   HS_WAIT_ACK | waiting for synchronised ack to answer req
//   HS_WAIT_REL | 4-phase only: req dropped, waiting for ack to return low
module cdc_hs_tx
    import cdc_hs_pkg::*;
#(
    parameter int DW          = 8,
    parameter int DEPTH       = 4,
    parameter int MODE        = HS_MODE_4PH,
    parameter int SYNC_STAGES = 2,
    localparam int LW         = $clog2(DEPTH + 1)
) (
    input  logic          clk_tx,
    input  logic          rst_b,
    input  logic          val,
    output logic          rdy,
    input  logic [DW-1:0] din,
    output logic          req,
    input  logic          ack,
    output logic [DW-1:0] dout,
    output logic [LW-1:0] level,
    output logic          busy,
    output logic          xfer_done,
    output logic          proto_err
);

    hs_tx_state_e           state;
    hs_tx_state_e           state_nxt;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic                   ack_s_q;
    logic                   ack_edge;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DW-1:0]          fifo_head;
    logic                   req_nxt;
    logic                   xfer_nxt;
    logic                   err_nxt;

    cdc_hs_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_tx (clk_tx),
        .rst_b  (rst_b),
        .push   (val),
        .din    (din),
        .pop    (fifo_pop),
        .head   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (level)
    );

    assign rdy   = ~fifo_full;
    assign busy  = (state != HS_IDLE) | ~fifo_empty;
    assign ack_s = ack_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_tx or negedge rst_b) begin
        if (!rst_b) begin
            ack_sync <= '0;
            ack_s_q  <= 1'b0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack};
            ack_s_q  <= ack_s;
        end
    end

    // 4-phase only treats a rising ack as a new answer; 2-phase treats any change.
    assign ack_edge = (MODE == HS_MODE_2PH) ? (ack_s ^ ack_s_q) : (ack_s & ~ack_s_q);
    assign err_nxt  = ack_edge & ((state == HS_IDLE) | (state == HS_SETUP));

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        req_nxt   = req;
        xfer_nxt  = 1'b0;
        case (state)
            HS_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = HS_SETUP;
                end
            end
            HS_SETUP: begin
                req_nxt   = (MODE == HS_MODE_2PH) ? ~req : 1'b1;
                state_nxt = HS_WAIT_ACK;
            end
            HS_WAIT_ACK: begin
                if (MODE == HS_MODE_2PH) begin
                    if (ack_s == req) begin
                        xfer_nxt  = 1'b1;
                        state_nxt = HS_IDLE;
                    end
                end else if (ack_s) begin
                    req_nxt   = 1'b0;
                    state_nxt = HS_WAIT_REL;
                end
            end
            HS_WAIT_REL: begin
                if (!ack_s) begin
                    xfer_nxt  = 1'b1;
                    state_nxt = HS_IDLE;
                end
            end
            default: state_nxt = HS_IDLE;
        endcase
    end

    always_ff @(posedge clk_tx or negedge rst_b) begin
        if (!rst_b) begin
            state     <= HS_IDLE;
            req       <= 1'b0;
            dout      <= '0;
            xfer_done <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            req       <= req_nxt;
            xfer_done <= xfer_nxt;
            proto_err <= err_nxt;
            if (fifo_pop) begin
                dout <= fifo_head;
            end
        end
    end

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Bench for cdc_hs_tx: one 4-phase and one 2-phase instance, each with a
// delayed-echo receiver model and an in-order word scoreboard.
module tb_cdc_hs_tx;

    localparam int DEPTH = 4;
    localparam logic [1:0] IS_2PH = 2'b10;  // instance 1 runs the 2-phase protocol

    logic            clk_tx = 1'b0;
    logic            rst_b;
    logic [1:0]      val;
    logic [1:0]      rdy;
    logic [1:0][7:0] din;
    logic [1:0][7:0] dout;
    logic [1:0]      req;
    logic [1:0]      ack;
    logic [1:0][2:0] level;
    logic [1:0]      busy;
    logic [1:0]      xfer_done;
    logic [1:0]      proto_err;

    logic [1:0]      stall;
    logic [1:0]      inj;
    logic [1:0][2:0] pipe;
    logic [1:0]      req_prev;
    logic [1:0][7:0] cur_word;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int sent_cnt[2];
    int xfer_cnt[2];
    int err_cnt[2];
    int req_tgl[2];
    int checks = 0;
    int errors = 0;

    always #5 clk_tx = ~clk_tx;

    assign ack[0] = pipe[0][2] ^ inj[0];
    assign ack[1] = pipe[1][2] ^ inj[1];

    cdc_hs_tx #(.DW(8), .DEPTH(DEPTH), .MODE(0), .SYNC_STAGES(2)) u_dut0 (
        .clk_tx(clk_tx), .rst_b(rst_b), .val(val[0]), .rdy(rdy[0]), .din(din[0]),
        .req(req[0]), .ack(ack[0]), .dout(dout[0]), .level(level[0]), .busy(busy[0]),
        .xfer_done(xfer_done[0]), .proto_err(proto_err[0]));

    cdc_hs_tx #(.DW(8), .DEPTH(DEPTH), .MODE(1), .SYNC_STAGES(2)) u_dut1 (
        .clk_tx(clk_tx), .rst_b(rst_b), .val(val[1]), .rdy(rdy[1]), .din(din[1]),
        .req(req[1]), .ack(ack[1]), .dout(dout[1]), .level(level[1]), .busy(busy[1]),
        .xfer_done(xfer_done[1]), .proto_err(proto_err[1]));

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_size(int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [7:0] exp_pop(int i);
        return (i == 0) ? q0.pop_front() : q1.pop_front();
    endfunction

    task automatic exp_push(int i, logic [7:0] d);
        if (i == 0) q0.push_back(d);
        else        q1.push_back(d);
        sent_cnt[i]++;
    endtask

    // Receiver: ack echoes req a few negedges later (frozen while stalled),
    // and each launched word is checked against the order of acceptance.
    always @(negedge clk_tx) begin
        if (!rst_b) begin
            pipe     = '0;
            req_prev = '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!stall[i]) pipe[i] = {pipe[i][1:0], req[i]};
                if (xfer_done[i]) xfer_cnt[i]++;
                if (proto_err[i]) err_cnt[i]++;
                if (req[i] != req_prev[i]) begin
                    req_tgl[i]++;
                    if (req[i] || IS_2PH[i]) begin
                        if (exp_size(i) == 0) begin
                            chk("rx_extra_word", 32'(exp_size(i)), 32'd1);
                        end else begin
                            cur_word[i] = exp_pop(i);
                            chk("rx_data", 32'(dout[i]), 32'(cur_word[i]));
                        end
                    end
                end
                req_prev[i] = req[i];
                if (req[i] != pipe[i][2]) chk("dout_stable", 32'(dout[i]), 32'(cur_word[i]));
            end
        end
    end

    task automatic push_word(int i, logic [7:0] d);
        int n = 0;
        @(negedge clk_tx);
        val[i] = 1'b1;
        din[i] = d;
        while (!rdy[i] && n < 300) begin
            @(negedge clk_tx);
            n++;
        end
        if (rdy[i]) exp_push(i, d);
        else        chk("push_timeout", 32'(rdy[i]), 32'd1);
    endtask

    task automatic release_val(int i);
        @(negedge clk_tx);
        val[i] = 1'b0;
    endtask

    task automatic wait_drain(int i);
        int n = 0;
        while ((busy[i] || exp_size(i) != 0) && n < 600) begin
            @(negedge clk_tx);
            n++;
        end
        repeat (2) @(negedge clk_tx);
        chk("drain_busy", 32'(busy[i]), 32'd0);
        chk("drain_xfer_cnt", 32'(xfer_cnt[i]), 32'(sent_cnt[i]));
    endtask

    // Push two words; dout must be loaded one edge after accept and req must
    // move one edge later still.
    task automatic latency_test(int i, logic [7:0] a, logic [7:0] b);
        logic r_before, r_after;
        int x0;
        r_before = IS_2PH[i] ? sent_cnt[i][0] : 1'b0;
        r_after  = IS_2PH[i] ? ~r_before : 1'b1;
        x0 = xfer_cnt[i];
        @(negedge clk_tx);
        val[i] = 1'b1;
        din[i] = a;
        chk("lat_rdy", 32'(rdy[i]), 32'd1);
        exp_push(i, a);
        @(negedge clk_tx);
        val[i] = 1'b0;
        chk("lat_k_req", 32'(req[i]), 32'(r_before));
        @(negedge clk_tx);
        chk("lat_k1_dout", 32'(dout[i]), 32'(a));
        chk("lat_k1_req", 32'(req[i]), 32'(r_before));
        @(negedge clk_tx);
        chk("lat_k2_req", 32'(req[i]), 32'(r_after));
        push_word(i, b);
        release_val(i);
        wait_drain(i);
        chk("lat_two_xfers", 32'(xfer_cnt[i] - x0), 32'd2);
        chk("lat_req_final", 32'(req[i]), 32'(IS_2PH[i] ? sent_cnt[i][0] : 1'b0));
    endtask

    task automatic rand_traffic(int i, int words);
        int g;
        for (int n = 0; n < words; n++) begin
            g = $urandom_range(0, 3);
            if (g != 0) begin
                @(negedge clk_tx);
                val[i] = 1'b0;
                repeat (g - 1) @(negedge clk_tx);
            end
            push_word(i, 8'($urandom));
        end
        release_val(i);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int snap;
        rst_b = 1'b0;
        val   = '0;
        din   = '0;
        stall = '0;
        inj   = '0;
        repeat (3) @(negedge clk_tx);
        chk("rst_rdy", 32'(rdy), 32'h3);
        chk("rst_req", 32'(req), 32'h0);
        rst_b = 1'b1;

        for (int c = 0; c < 20; c++) begin
            @(negedge clk_tx);
            chk("idle_req", 32'(req), 32'h0);
            chk("idle_dout", 32'(dout), 32'h0);
            chk("idle_rdy", 32'(rdy), 32'h3);
            chk("idle_level", 32'(level), 32'h0);
            chk("idle_busy", 32'(busy), 32'h0);
        end

        latency_test(0, 8'hA5, 8'h3C);
        latency_test(1, 8'hA5, 8'h3C);

        // Fill with the receiver stalled: one word sits in the open handshake,
        // DEPTH more fill the FIFO, and the next must wait for rdy.
        stall[0] = 1'b1;
        for (int w = 1; w <= 5; w++) push_word(0, 8'(w));
        @(negedge clk_tx);
        din[0] = 8'd6;
        chk("full_rdy", 32'(rdy[0]), 32'd0);
        chk("full_level", 32'(level[0]), 32'(DEPTH));
        repeat (5) begin
            @(negedge clk_tx);
            chk("full_hold_rdy", 32'(rdy[0]), 32'd0);
        end
        stall[0] = 1'b0;
        n = 0;
        while (!rdy[0] && n < 100) begin
            @(negedge clk_tx);
            n++;
        end
        chk("full_rdy_return", 32'(rdy[0]), 32'd1);
        if (rdy[0]) exp_push(0, 8'd6);
        @(negedge clk_tx);
        val[0] = 1'b0;
        chk("refill_level", 32'(level[0]), 32'(DEPTH));
        wait_drain(0);

        // Push on the same edge that pops the next word (the edge ending the
        // xfer_done cycle) with two words queued.
        stall[0] = 1'b1;
        push_word(0, 8'h11);
        push_word(0, 8'h22);
        push_word(0, 8'h33);
        release_val(0);
        chk("pp_level_pre", 32'(level[0]), 32'd2);
        stall[0] = 1'b0;
        n = 0;
        while (!xfer_done[0] && n < 100) begin
            @(negedge clk_tx);
            n++;
        end
        chk("pp_xfer_seen", 32'(xfer_done[0]), 32'd1);
        chk("pp_level_at", 32'(level[0]), 32'd2);
        val[0] = 1'b1;
        din[0] = 8'h44;
        exp_push(0, 8'h44);
        @(negedge clk_tx);
        val[0] = 1'b0;
        chk("pp_level_post", 32'(level[0]), 32'd2);
        wait_drain(0);

        // Spurious ack pulse while idle.
        snap = err_cnt[0];
        @(negedge clk_tx);
        inj[0] = 1'b1;
        repeat (4) @(negedge clk_tx);
        inj[0] = 1'b0;
        repeat (10) @(negedge clk_tx);
        chk("spur_err_pulses", 32'(err_cnt[0] - snap), 32'd1);
        chk("spur_req", 32'(req[0]), 32'd0);
        chk("spur_level", 32'(level[0]), 32'd0);
        chk("spur_busy", 32'(busy[0]), 32'd0);
        push_word(0, 8'h5A);
        release_val(0);
        wait_drain(0);

        fork
            rand_traffic(0, 30);
            rand_traffic(1, 30);
            begin
                repeat (400) begin
                    @(negedge clk_tx);
                    stall = 2'($urandom_range(0, 3) == 0) | (2'($urandom_range(0, 3) == 0) << 1);
                end
            end
        join
        stall = '0;
        wait_drain(0);
        wait_drain(1);

        chk("tot_tgl_4ph", 32'(req_tgl[0]), 32'(2 * sent_cnt[0]));
        chk("tot_tgl_2ph", 32'(req_tgl[1]), 32'(sent_cnt[1]));
        chk("tot_err_4ph", 32'(err_cnt[0]), 32'd1);
        chk("tot_err_2ph", 32'(err_cnt[1]), 32'd0);

        // Reset in the middle of an open handshake: req must fall immediately.
        stall[0] = 1'b1;
        push_word(0, 8'hC3);
        release_val(0);
        n = 0;
        while (!req[0] && n < 20) begin
            @(negedge clk_tx);
            n++;
        end
        chk("midrst_req_up", 32'(req[0]), 32'd1);
        #2;
        rst_b = 1'b0;
        #1;
        chk("midrst_req_async", 32'(req[0]), 32'd0);
        chk("midrst_level", 32'(level[0]), 32'd0);
        chk("midrst_rdy", 32'(rdy[0]), 32'd1);
        q0.delete();
        q1.delete();
        repeat (3) @(negedge clk_tx);
        stall = '0;
        rst_b = 1'b1;
        repeat (5) @(negedge clk_tx);
        chk("post_rst_req", 32'(req), 32'h0);
        chk("post_rst_dout", 32'(dout), 32'h0);
        chk("post_rst_busy", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
